// File: rtl/light_phase_monitor_if.sv
// Lamp-pin, control and status bundle for the traffic-light phase monitor.
// master drives the lamp pins and controls; slave is the monitor.
interface light_phase_monitor_if;
  logic       R;
  logic       G;
  logic       tick_1hz;
  logic       override;
  logic       clr_err;
  logic [1:0] phase;
  logic       phase_valid;
  logic [3:0] dwell;
  logic       seq_err;
  logic       dwell_err;
  logic [2:0] err_code;

  modport master (
    output R, G, tick_1hz, override, clr_err,
    input  phase, phase_valid, dwell,
    input  seq_err, dwell_err, err_code
  );

  modport slave (
    input  R, G, tick_1hz, override, clr_err,
    output phase, phase_valid, dwell,
    output seq_err, dwell_err, err_code
  );
endinterface

// File: rtl/light_phase_monitor.sv
// Traffic-light phase monitor: debounces lamp pins, tracks phase and
// dwell time, and flags sequence and dwell faults with a sticky first code.
module light_phase_monitor #(
  parameter int DWELL_TICKS = 11,
  parameter int DWELL_TOL   = 1,
  parameter int STABLE_CYC  = 4
) (
  input logic                   clk,
  input logic                   reset,
  light_phase_monitor_if.slave  bus
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [1:0] RED  = 2'b00;
  localparam logic [1:0] YEL  = 2'b01;
  localparam logic [1:0] GRN  = 2'b10;
  localparam logic [1:0] DARK = 2'b11;

  localparam logic [2:0] E_SEQ   = 3'b001;
  localparam logic [2:0] E_SHORT = 3'b010;
  localparam logic [2:0] E_STUCK = 3'b011;
  localparam logic [2:0] E_DARK  = 3'b100;

  localparam logic [3:0] LO    = 4'(DWELL_TICKS - DWELL_TOL);
  localparam logic [3:0] HI_M1 = 4'(DWELL_TICKS + DWELL_TOL);
  localparam int         CW    = $clog2(STABLE_CYC + 1);

  state_t      state, state_n;
  logic        r_s1, r_s2, g_s1, g_s2;
  logic [1:0]  dec, cand;
  logic [CW-1:0] cnt;
  logic        commit;

  logic [1:0]  phase_q, phase_n;
  logic        valid_q, valid_n;
  logic [3:0]  dwell_q, dwell_n, dwell_inc;
  logic        first_q, first_n;
  logic        seq_q, seq_n, derr_q, derr_n;
  logic [2:0]  code_q, code_n;

  logic        seq_hit, len_hit, stuck_hit, legal;
  logic [2:0]  seq_code;
  logic        seq_c, derr_c;
  logic [2:0]  code_c;

  always_comb begin
    dec = DARK;
    unique case ({r_s2, g_s2})
      2'b01: dec = RED;
      2'b11: dec = YEL;
      2'b10: dec = GRN;
      2'b00: dec = DARK;
    endcase
  end

  // cnt holds how many consecutive cycles dec has matched cand
  assign commit = (dec != phase_q) &&
    ((STABLE_CYC <= 1) ||
     (dec == cand && cnt == CW'(STABLE_CYC - 1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      g_s1 <= 1'b0;
      g_s2 <= 1'b0;
      cand <= DARK;
      cnt  <= '0;
    end else begin
      r_s1 <= bus.R;
      r_s2 <= r_s1;
      g_s1 <= bus.G;
      g_s2 <= g_s1;
      if (dec == phase_q || commit) begin
        cnt <= '0;
      end else if (dec != cand) begin
        cand <= dec;
        cnt  <= CW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign legal = (phase_q == RED && dec == YEL) ||
                 (phase_q == YEL && dec == GRN) ||
                 (phase_q == GRN && dec == RED);

  assign dwell_inc = (dwell_q == 4'd15) ? 4'd15 : dwell_q + 4'd1;

  always_comb begin
    state_n   = state;
    phase_n   = phase_q;
    valid_n   = valid_q;
    dwell_n   = dwell_q;
    first_n   = first_q;
    seq_hit   = 1'b0;
    len_hit   = 1'b0;
    stuck_hit = 1'b0;
    seq_code  = E_SEQ;
    unique case (state)
      IDLE: begin
        if (commit && dec != DARK) begin
          state_n = TRACK;
          phase_n = dec;
          valid_n = 1'b1;
          dwell_n = bus.tick_1hz ? 4'd1 : 4'd0;
          first_n = 1'b1;
        end
      end
      TRACK: begin
        if (commit) begin
          phase_n = dec;
          dwell_n = bus.tick_1hz ? 4'd1 : 4'd0;
          first_n = 1'b0;
          if (!bus.override) begin
            if (dec == DARK) begin
              seq_hit  = 1'b1;
              seq_code = E_DARK;
            end else if (phase_q != DARK && !legal) begin
              seq_hit = 1'b1;
            end
            // dwell_q is the pre-tick value even if a tick coincides
            len_hit = !first_q && (dwell_q < LO);
          end
        end else if (bus.tick_1hz) begin
          dwell_n   = dwell_inc;
          stuck_hit = !bus.override && (dwell_q == HI_M1);
        end
      end
    endcase
  end

  always_comb begin
    seq_c  = bus.clr_err ? 1'b0 : seq_q;
    derr_c = bus.clr_err ? 1'b0 : derr_q;
    code_c = bus.clr_err ? 3'b000 : code_q;
    seq_n  = seq_c | seq_hit;
    derr_n = derr_c | len_hit | stuck_hit;
    code_n = code_c;
    if (!seq_c && !derr_c) begin
      unique case (1'b1)
        seq_hit:   code_n = seq_code;
        len_hit:   code_n = E_SHORT;
        stuck_hit: code_n = E_STUCK;
        default:   code_n = code_c;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      phase_q <= DARK;
      valid_q <= 1'b0;
      dwell_q <= 4'd0;
      first_q <= 1'b0;
      seq_q   <= 1'b0;
      derr_q  <= 1'b0;
      code_q  <= 3'b000;
    end else begin
      state   <= state_n;
      phase_q <= phase_n;
      valid_q <= valid_n;
      dwell_q <= dwell_n;
      first_q <= first_n;
      seq_q   <= seq_n;
      derr_q  <= derr_n;
      code_q  <= code_n;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.phase_valid = valid_q;
  assign bus.dwell       = dwell_q;
  assign bus.seq_err     = seq_q;
  assign bus.dwell_err   = derr_q;
  assign bus.err_code    = code_q;

endmodule

// File: tb/tb_light_phase_monitor.sv
// Scenario bench for light_phase_monitor with a commit scoreboard.
// Expected commits are queued when lamp pins change, checked on phase change.
module tb_light_phase_monitor;

  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 2;

  typedef struct {
    logic [1:0] ph;
    logic [3:0] pre;
    logic       se;
    logic       de;
    logic [2:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  light_phase_monitor_if bus();

  light_phase_monitor #(
    .DWELL_TICKS(11),
    .DWELL_TOL(1),
    .STABLE_CYC(STABLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic se,
                           input logic de, input logic [2:0] ec);
    checks++;
    if (bus.seq_err !== se || bus.dwell_err !== de ||
        bus.err_code !== ec) begin
      errors++;
      $display("FAIL %s: got seq=%b dwell=%b code=%b expected seq=%b dwell=%b code=%b",
               name, bus.seq_err, bus.dwell_err, bus.err_code, se, de, ec);
    end
  endtask

  task automatic lamp(input logic r, input logic g,
                      input logic [1:0] ph, input logic [3:0] pre,
                      input logic se, input logic de,
                      input logic [2:0] ec, input string name);
    exp_t e;
    int n;
    logic [1:0] old;
    logic [3:0] pd;
    e.ph = ph; e.pre = pre; e.se = se; e.de = de; e.ec = ec;
    sb.push_back(e);
    old = bus.phase;
    pd  = bus.dwell;
    bus.R = r;
    bus.G = g;
    n = 0;
    while (bus.phase === old && n < 20) begin
      step();
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, n, LAT);
    end
    checks++;
    if (bus.phase !== e.ph) begin
      errors++;
      $display("FAIL %s phase: got %b expected %b", name, bus.phase, e.ph);
    end
    checks++;
    if (pd !== e.pre) begin
      errors++;
      $display("FAIL %s pre_dwell: got %0d expected %0d", name, pd, e.pre);
    end
    checks++;
    if (bus.dwell !== 4'd0 || bus.phase_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s post: got dwell=%0d valid=%b expected dwell=0 valid=1",
               name, bus.dwell, bus.phase_valid);
    end
    chk_flags({name, " flags"}, e.se, e.de, e.ec);
  endtask

  task automatic clear();
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk_flags("clr_err", 1'b0, 1'b0, 3'b000);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, " phase"}, int'(bus.phase), 3);
    chk({name, " valid"}, int'(bus.phase_valid), 0);
    chk({name, " dwell"}, int'(bus.dwell), 0);
    chk_flags({name, " flags"}, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    check_reset_state("reset");
    reset = 1'b1;
    repeat (3) step();
    chk("idle dark", int'(bus.phase), 3);
  endtask

  task automatic test_glitch();
    bit moved = 0;
    lamp(1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0, 3'b000, "first red");
    bus.R = 1'b1;
    repeat (3) step();
    bus.R = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.phase !== 2'b00) moved = 1;
    end
    chk("glitch held", int'(moved), 0);
    chk_flags("glitch flags", 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_normal();
    ticks(11);
    chk("red dwell", int'(bus.dwell), 11);
    lamp(1'b1, 1'b1, 2'b01, 4'd11, 1'b0, 1'b0, 3'b000, "n yellow");
    ticks(11);
    lamp(1'b1, 1'b0, 2'b10, 4'd11, 1'b0, 1'b0, 3'b000, "n green");
    ticks(11);
    lamp(1'b0, 1'b1, 2'b00, 4'd11, 1'b0, 1'b0, 3'b000, "n red");
    ticks(11);
    lamp(1'b1, 1'b1, 2'b01, 4'd11, 1'b0, 1'b0, 3'b000, "n yellow2");
  endtask

  task automatic test_seq_err();
    reset = 1'b0;
    step();
    reset = 1'b1;
    lamp(1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0, 3'b000, "s red");
    ticks(11);
    lamp(1'b1, 1'b0, 2'b10, 4'd11, 1'b1, 1'b0, 3'b001, "s red->green");
    ticks(11);
    lamp(1'b1, 1'b1, 2'b01, 4'd11, 1'b1, 1'b0, 3'b001, "s green->yel");
    ticks(5);
    lamp(1'b1, 1'b0, 2'b10, 4'd5, 1'b1, 1'b1, 3'b001, "s short yel");
  endtask

  task automatic test_stuck();
    clear();
    ticks(12);
    chk("stuck dwell12", int'(bus.dwell), 12);
    chk_flags("stuck pre", 1'b0, 1'b0, 3'b000);
    ticks(1);
    chk("stuck dwell13", int'(bus.dwell), 13);
    chk_flags("stuck hit", 1'b0, 1'b1, 3'b011);
    clear();
    ticks(3);
    chk("dwell sat", int'(bus.dwell), 15);
    chk_flags("no reflag", 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_override();
    lamp(1'b0, 1'b1, 2'b00, 4'd15, 1'b0, 1'b0, 3'b000, "o red");
    ticks(3);
    bus.override = 1'b1;
    lamp(1'b1, 1'b0, 2'b10, 4'd3, 1'b0, 1'b0, 3'b000, "o red->green");
    bus.override = 1'b0;
  endtask

  task automatic test_reset_mid();
    ticks(6);
    chk("mid dwell", int'(bus.dwell), 6);
    reset = 1'b0;
    step();
    check_reset_state("mid reset");
    reset = 1'b1;
    lamp(1'b1, 1'b0, 2'b10, 4'd0, 1'b0, 1'b0, 3'b000, "r green");
    ticks(2);
    lamp(1'b0, 1'b1, 2'b00, 4'd2, 1'b0, 1'b0, 3'b000, "r exempt");
  endtask

  task automatic test_dark();
    ticks(11);
    lamp(1'b0, 1'b0, 2'b11, 4'd11, 1'b1, 1'b0, 3'b100, "d dark");
    ticks(11);
    lamp(1'b1, 1'b1, 2'b01, 4'd11, 1'b1, 1'b0, 3'b100, "d yellow");
  endtask

  task automatic test_back_to_back();
    clear();
    ticks(9);
    bus.R = 1'b1;
    bus.G = 1'b0;
    repeat (LAT - 1) step();
    chk("b2b before", int'(bus.phase), 1);
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    chk("b2b phase", int'(bus.phase), 2);
    chk("b2b dwell", int'(bus.dwell), 1);
    chk_flags("b2b flags", 1'b0, 1'b1, 3'b010);
  endtask

  initial begin
    bus.R = 1'b0;
    bus.G = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.override = 1'b0;
    bus.clr_err = 1'b0;
    test_reset();
    test_glitch();
    test_normal();
    test_seq_err();
    test_stuck();
    test_override();
    test_reset_mid();
    test_dark();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_phase_monitor.md
LIGHT_PHASE_MONITOR -- requirements
Module: light_phase_monitor

Interface
REQ-001 SHALL have parameter DWELL_TICKS, default 11, meaning the expected number of 1 Hz ticks per phase.
REQ-002 SHALL have parameter DWELL_TOL, default 1, meaning the allowed ± deviation from DWELL_TICKS in ticks.
REQ-003 SHALL have parameter STABLE_CYC, default 4, meaning the number of clk cycles lamp inputs must hold before a change is accepted.
REQ-004 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port tick_1hz  input  1  one-clk-cycle strobe at 1 Hz.
REQ-007 SHALL have ports R, G  input  1 each  lamp drive pins from the light controller; may be asynchronous to clk.
REQ-008 SHALL have port override  input  1  manual-override indication; suppresses sequence and dwell checks.
REQ-009 SHALL have port clr_err  input  1  clears the sticky errors.
REQ-010 SHALL have port phase  output  2  decoded phase: 00 red, 01 yellow, 10 green, 11 dark.
REQ-011 SHALL have port phase_valid  output  1  high once the first non-dark phase has been accepted.
REQ-012 SHALL have port dwell  output  4  ticks counted in the current phase, saturating at 15.
REQ-013 SHALL have ports seq_err, dwell_err  output  1 each  sticky fault flags.
REQ-014 SHALL have port err_code  output  3  code of the first error since the last clear.

Function
REQ-015 SHALL pass R and G through a 2-flop synchronizer before any other use.
REQ-016 SHALL decode the synchronized {R,G} as follows: 01 → red, 11 → yellow, 10 → green, 00 → dark.
REQ-017 SHALL commit a decoded value that differs from phase only after it has been identical for STABLE_CYC consecutive cycles.
  - A stable pin change appears on phase exactly STABLE_CYC+2 cycles later.
  - Shorter glitches are ignored.
REQ-018 SHALL implement state machine IDLE/TRACK, with IDLE entered at reset.
  - In IDLE, the first committed non-dark phase moves the FSM to TRACK, sets phase_valid, and loads dwell=0.
  - That phase is exempt from the dwell check.
REQ-019 SHALL, in TRACK, increment dwell on each tick_1hz, saturating at 15.
REQ-020 SHALL, on every commit in TRACK, check the transition.
  - Legal sequence: red→yellow→green→red.
  - Any other transition, including to dark, sets seq_err.
  - err_code: 001 for an illegal colour transition, 100 for dark.
REQ-021 SHALL, on every commit in TRACK, check the outgoing phase's dwell.
  - dwell < DWELL_TICKS−DWELL_TOL sets dwell_err with err_code 010.
  - dwell is then loaded to 0.
REQ-022 SHALL set dwell_err with err_code 011 (stuck) in the cycle dwell reaches DWELL_TICKS+DWELL_TOL+1 without a commit; this flags once per phase.
REQ-023 SHALL suppress all checks (REQ-020..022) while override=1 in the commit cycle or the stuck cycle; the commit itself still occurs.
REQ-024 SHALL, when tick_1hz coincides with a commit, check the dwell value before the tick and then load dwell=1.
REQ-025 SHALL, after a commit to dark in TRACK, remain in TRACK; the next non-dark commit is exempt from the sequence check and clears no flags.
REQ-026 SHALL write err_code only when both flags are clear, so that it holds the first error.
REQ-027 SHALL clear seq_err, dwell_err and err_code on clr_err=1; an error detected in the same cycle wins and is recorded.
REQ-028 SHALL keep dwell arithmetic 4-bit unsigned with compare thresholds computed at elaboration; DWELL_TICKS+DWELL_TOL+1 ≤ 15 is required.

Reset
REQ-029 SHALL, while reset=0 at a clk edge, load the following values:
  - FSM = IDLE.
  - phase = 11, phase_valid = 0, dwell = 0.
  - seq_err = 0, dwell_err = 0, err_code = 000.
  - Synchronizer and stability counter cleared.
REQ-030 SHALL abandon any pending commit on reset asserted mid-operation; after release, checking restarts as from power-up.

Verification
REQ-031 SHALL be verified with normal cycle: DWELL_TICKS=11; feed yellow, green, red, yellow with 11 ticks per phase → phase follows 01,10,00,01 with STABLE_CYC+2 latency, dwell=11 at each commit, no errors.
REQ-032 SHALL be verified with glitch rejection: while red, pulse {R,G}=11 for 3 cycles → phase stays 00, no error.
REQ-033 SHALL be verified with illegal sequence: red→green after 11 ticks → seq_err=1, err_code=001; then a short yellow of 5 ticks → dwell_err=1, err_code stays 001.
REQ-034 SHALL be verified with stuck lamp: hold green 13 ticks → dwell_err=1, err_code=011 on the 13th tick; clr_err → all clear; dwell saturates at 15.
REQ-035 SHALL be verified with override: override=1, red→green after 3 ticks → no errors, phase=10, dwell=0.
REQ-036 SHALL be verified with reset mid-phase: reset=0 for one cycle while dwell=6 → all outputs at reset values; the next phase is accepted without checks.
